muldiv_seq: RTL

- Iterative signed multiply/divide sequencer that owns the HI and LO registers of the multicycle CPU.
- Started by the main control unit for MULT/DIV; runs one iteration per clock; pulses done when finished.
- hi_out/lo_out feed the MEMtoReg mux for MFHI/MFLO.
- Reports divide-by-zero to the control unit so it can raise an exception.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_seq_div_step.sv | 27 ++
 rtl/muldiv_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Iteration counter width: must hold 0..ITER-1 with one bit of headroom.
  function automatic int cnt_width(input int iter);
    return $clog2(iter) + 1;
  endfunction

  localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // Remainder shifted left with the next dividend bit; one extra bit so the
  // trial subtraction's borrow shows up in the MSB.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign fits    = ~diff[WIDTH];

  // When the divisor does not fit, shifted < divisor < 2^WIDTH, so dropping
  // the top bit of the restored value loses nothing.
  assign rem_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV unit owning HI/LO. Booth radix-2 multiply and
// restoring divide, one step per clock. All status outputs are registered and
// trail the state register by one cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = cnt_width(ITER);
  localparam int AW = 2*WIDTH + 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             dz_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] opnd_q;     // multiplicand (MULT) or |divisor| (DIV)
  logic [AW-1:0]    acc_q;      // MULT: {A, Q, q-1}; DIV: {-, rem, quo}
  logic [AW-1:0]    acc_d;
  logic             busy_q, done_q, div_zero_q, hlw_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   upper_ext, m_ext, booth_sum;
  logic [AW-1:0]    booth_nxt;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  // Booth step: add/sub in WIDTH+1 bits so the most negative multiplicand
  // cannot overflow A before the arithmetic shift.
  always_comb begin
    upper_ext = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
    m_ext     = {opnd_q[WIDTH-1], opnd_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = upper_ext + m_ext;
      2'b10:   booth_sum = upper_ext - m_ext;
      default: booth_sum = upper_ext;
    endcase
    booth_nxt = {booth_sum, acc_q[WIDTH:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i (acc_q[WIDTH-1:0]),
    .div_i (opnd_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  // Sign fix-up of the magnitude results, applied when HI/LO are written.
  always_comb begin
    quo_res = qneg_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    rem_res = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Accumulator next value: load on accept, one step per MULT/DIV cycle.
  always_comb begin
    acc_d = acc_q;
    case (state_q)
      IDLE: if (start) begin
        if (op == OP_MULT) acc_d = {{WIDTH{1'b0}}, b_in, 1'b0};
        else               acc_d = {1'b0, {WIDTH{1'b0}}, a_mag};
      end
      MULT:    acc_d = booth_nxt;
      DIV:     acc_d = {1'b0, rem_nxt, quo_nxt};
      default: acc_d = acc_q;
    endcase
  end

  // Control FSM with registered status outputs and the HI/LO registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      dz_q       <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hlw_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      acc_q      <= acc_d;
      busy_q     <= (state_q != IDLE);
      done_q     <= (state_q == DONE);
      div_zero_q <= (state_q == DONE) &&  dz_q;
      hlw_q      <= (state_q == DONE) && !dz_q;
      case (state_q)
        IDLE: if (start) begin
          op_q  <= op;
          cnt_q <= '0;
          dz_q  <= 1'b0;
          if (op == OP_MULT) begin
            opnd_q  <= a_in;
            state_q <= MULT;
          end else begin
            opnd_q <= b_mag;
            qneg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rneg_q <= a_in[WIDTH-1];
            if (b_in == '0) begin
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= DIV;
            end
          end
        end
        MULT, DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER-1)) state_q <= DONE;
        end
        DONE: begin
          if (!dz_q) begin
            if (op_q == OP_MULT) begin
              hi_q <= acc_q[AW-1:WIDTH+1];
              lo_q <= acc_q[WIDTH:1];
            end else begin
              hi_q <= rem_res;
              lo_q <= quo_res;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_zero    = div_zero_q;
  assign hi_lo_write = hlw_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule
